// File: rtl/spike_injector.sv
// Spike network transmit side: buffers neuron fire events and injects one
// 34-bit packet per granted cycle, with an end-of-tick flush handshake.
package spike_injector_pkg;
   typedef struct packed {
      logic [1:0] dest_core;
      logic [3:0] delay;
      logic [7:0] dest_axon;
      logic [7:0] neuron;
   } spike_evt_t;
endpackage

module spike_injector
   import spike_injector_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       core_id,
   input  logic             spike_valid,
   output logic             spike_ready,
   input  logic [7:0]       spike_neuron,
   input  logic [1:0]       spike_dest_core,
   input  logic [7:0]       spike_dest_axon,
   input  logic [3:0]       spike_delay,
   input  logic             tick_end,
   input  logic             inject_grant,
   output logic [33:0]      inject_packet,
   output logic             tick_done,
   output logic [CNT_W-1:0] fifo_count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

   state_t           state;
   spike_evt_t       mem [DEPTH];
   spike_evt_t       wr_evt;
   spike_evt_t       head;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push;
   logic             pop;

   // Ready is gated by reset so no event is taken while the core is held.
   assign spike_ready = rst && (state == RUN) && (fifo_count < CNT_W'(DEPTH));
   assign push        = spike_valid && spike_ready;
   assign pop         = inject_grant && (fifo_count != '0);
   assign wr_evt      = {spike_dest_core, spike_delay, spike_dest_axon, spike_neuron};
   assign head        = mem[rd_ptr];

   // Event storage carries no reset; occupancy is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_evt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fifo_count    <= '0;
         inject_packet <= '0;
         tick_done     <= 1'b0;
         state         <= RUN;
      end else begin
         tick_done <= 1'b0;

         if (push) wr_ptr <= wr_ptr + PTR_W'(1);

         if (pop) begin
            rd_ptr        <= rd_ptr + PTR_W'(1);
            inject_packet <= {1'b0, head.dest_core, head.delay, head.dest_axon,
                              head.neuron, core_id, 8'h00, 1'b1};
         end else begin
            inject_packet <= '0;
         end

         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase

         // DONE is entered only once the last packet has been registered out.
         case (state)
            RUN: begin
               if (tick_end) state <= FLUSH;
            end
            FLUSH: begin
               if ((fifo_count == '0) && !pop) begin
                  state     <= DONE;
                  tick_done <= 1'b1;
               end
            end
            DONE:    state <= RUN;
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: doc/spike_injector.md
Name: spike_injector

Overview:
- Transmit end of the inter-core spike network. Takes neuron fire events from the local core's neuron block and buffers them in a FIFO.
- Formats each event as a 34-bit packet and injects one packet per granted cycle onto the core's router link.
- Provides an end-of-tick flush so the core controller knows when every spike from the current tick has left the core.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- CNT_W, $clog2(DEPTH+1), width of fifo_count.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset; 0 resets immediately.
- core_id  input  2  this core's id; static after reset.
- spike_valid  input  1  fire event present.
- spike_ready  output  1  injector can accept an event this cycle.
- spike_neuron  input  8  source neuron index.
- spike_dest_core  input  2  destination core id.
- spike_dest_axon  input  8  destination axon index.
- spike_delay  input  4  delivery delay in ticks.
- tick_end  input  1  one-cycle pulse: neuron block finished emitting for this tick.
- inject_grant  input  1  router link free this cycle.
- inject_packet  output  34  packet to router; all-zero means idle.
- tick_done  output  1  one-cycle pulse: all spikes of the tick injected.
- fifo_count  output  CNT_W  current FIFO occupancy.

Behaviour:
- Packet format:
  - [33] = 0
  - [32:31] = dest core
  - [30:27] = delay
  - [26:19] = dest axon
  - [18:11] = source neuron
  - [10:9] = core_id
  - [8:1] = 0
  - [0] = 1, so every valid packet is nonzero.
- Reset (rst=0, asynchronous):
  - FIFO pointers and count cleared.
  - inject_packet = 0, tick_done = 0, state = RUN.
  - Contents of in-flight events are discarded.
  - spike_ready = 0 while rst=0.
- Accept:
  - Push when spike_valid && spike_ready.
  - spike_ready = (state==RUN) && (fifo_count < DEPTH), combinational from registered state.
  - At full, ready stays 0 even if a pop happens in the same cycle.
  - spike_valid while not ready: the event is not taken; the source must hold it.
- Inject:
  - inject_packet is registered.
  - Each cycle: if inject_grant && fifo_count != 0, pop the head and register its packet; otherwise inject_packet <= 0.
  - Each packet is presented for exactly one cycle. No retry.
  - Minimum latency: push accepted in cycle N, packet visible in cycle N+2 (grant high in N+1).
- Count:
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM:
  - RUN: tick_end=1 -> FLUSH.
  - FLUSH: spike_ready=0. Pops continue per grant. When fifo_count==0 and no pop in this cycle -> DONE.
  - DONE: tick_done=1 for this cycle only; next state RUN.
  - tick_end in FLUSH or DONE is ignored.
  - tick_end with an empty FIFO: RUN -> FLUSH -> DONE, so tick_done rises 2 cycles after tick_end.
  - tick_end and spike_valid in the same RUN cycle: that spike is accepted and belongs to the flushing tick.
  - tick_done asserts no earlier than the cycle after the last packet appears on inject_packet.
- Destination equal to core_id is still injected; local delivery is the router's job.

Test Plan:
- Reset mid-flush:
  - Stimulus: push 3 events, pulse tick_end, pull rst low for 1 cycle.
  - Response: inject_packet=0, fifo_count=0, spike_ready=0 during reset, then 1 after release; no tick_done.
- Single spike:
  - Stimulus: core_id=1; event neuron=0x05, dest_core=2, axon=0x3C, delay=3; grant held 1.
  - Response: 2 cycles after accept, inject_packet = {1'b0, 2'd2, 4'd3, 8'h3C, 8'h05, 2'd1, 8'h00, 1'b1} for exactly one cycle, then 0.
- Backpressure full:
  - Stimulus: grant=0; offer 20 events.
  - Response: 16 accepted, fifo_count=16, spike_ready=0. Then raise grant: 16 packets in FIFO order on consecutive cycles, then fifo_count=0.
- Flush:
  - Stimulus: 4 events queued, tick_end pulsed, grant alternating 1/0.
  - Response: spike_ready=0 from the cycle after tick_end; 4 packets emitted; tick_done pulses once, the cycle after FIFO empties; spike_ready returns to 1 the following cycle.
- Empty tick:
  - Stimulus: tick_end with empty FIFO.
  - Response: tick_done pulses 2 cycles later; inject_packet stays 0.
- Concurrent push and pop:
  - Stimulus: fifo_count=5, push with grant=1 for 10 cycles.
  - Response: count stays 5; pointers wrap with no loss or reordering of packets.
